spi_txn_queue: RTL and testbench
================================

SPI_TXN_QUEUE -- requirements
Module: spi_txn_queue

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, byte width shared with the SPI core.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, entries per FIFO, power of two, at least 2.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port wr_en  input  1  push wr_data into the TX FIFO.
REQ-006 SHALL have port wr_data  input  DATA_BITS  byte to transmit.
REQ-007 SHALL have port tx_full  output  1  TX FIFO full.
REQ-008 SHALL have port rd_en  input  1  pop the RX FIFO.
REQ-009 SHALL have port rd_data  output  DATA_BITS  RX FIFO head byte.
REQ-010 SHALL have port rx_empty  output  1  RX FIFO empty.
REQ-011 SHALL have port spi_start  output  1  start request to the SPI master.
REQ-012 SHALL have port spi_master_out  output  DATA_BITS  byte presented to the SPI master.
REQ-013 SHALL have port spi_busy  input  1  SPI master busy.
REQ-014 SHALL have port spi_done  input  1  one-cycle SPI transfer-complete pulse.
REQ-015 SHALL have port spi_master_in  input  DATA_BITS  byte received by the SPI master.
REQ-016 SHALL have port idle  output  1  FSM in IDLE and TX FIFO empty.

Function
REQ-017 FSM states SHALL be IDLE, LAUNCH, WAIT_DONE and STORE.
REQ-018 IDLE SHALL go to LAUNCH when the TX FIFO is non-empty and spi_busy=0, popping the head byte into spi_master_out on that edge.
REQ-019 LAUNCH SHALL drive spi_start=1 until spi_busy=1 is sampled, then go to WAIT_DONE with spi_start=0 on the next cycle.
REQ-020 WAIT_DONE SHALL capture spi_master_in on the cycle spi_done=1, then go to STORE.
REQ-021 STORE SHALL push the captured byte into the RX FIFO and go to IDLE; if the RX FIFO is full it SHALL stay in STORE and push when space frees.
REQ-022 spi_master_out SHALL stay stable from the pop through the end of WAIT_DONE.
REQ-023 A write with tx_full=1 SHALL be dropped without corrupting the FIFO.
REQ-024 A read with rx_empty=1 SHALL be ignored.
REQ-025 A simultaneous push and pop on the same FIFO SHALL succeed at any occupancy except push-when-full-without-pop, so that occupancy is unchanged.
REQ-026 Pointers SHALL be log2(FIFO_DEPTH)+1 bits; the extra MSB SHALL distinguish full from empty, and pointers SHALL wrap modulo 2*FIFO_DEPTH.
REQ-027 rd_data SHALL be the RX head combinationally, valid whenever rx_empty=0.
REQ-028 Back-to-back transactions SHALL need at most 2 idle clk cycles between the end of STORE and the next spi_start.

Reset
REQ-029 While reset=0, the block SHALL go to IDLE with both FIFOs emptied, spi_start=0, spi_master_out=0, tx_full=0, rx_empty=1, rd_data=0 and idle=1.
REQ-030 Reset asserted mid-transaction SHALL abort immediately; no RX push SHALL occur, and the in-flight SPI transfer is owned by the SPI core's own reset.

Configuration
REQ-031 Macro SPI_TXN_QUEUE_ERR_EN SHALL, when defined, add output tx_ovf and output rx_ovf (1 bit each, sticky, cleared only by reset).
REQ-032 With SPI_TXN_QUEUE_ERR_EN, tx_ovf SHALL be set by a dropped write, and rx_ovf SHALL be set by any cycle spent stalled in STORE.
REQ-033 Without SPI_TXN_QUEUE_ERR_EN, those ports and their logic SHALL be absent, with behaviour otherwise identical.

Structure
REQ-034 A package spi_pkg SHALL hold the state enum type and the DATA_BITS/FIFO_DEPTH defaults.
REQ-035 One sub-module, spi_sync_fifo, SHALL be instantiated twice (TX and RX).

Verification
REQ-036 Reset with no writes -> idle=1, spi_start=0, rx_empty=1.
REQ-037 Write 0xA5 with the SPI model returning 0x77 -> spi_master_out=0xA5 while busy, then rd_data=0x77, rx_empty=0.
REQ-038 Write 0xA1, 0xA3 back-to-back with model returns 0x76, 0x46 -> two SPI transfers in order, and RX reads 0x76 then 0x46.
REQ-039 Write 5 bytes with FIFO_DEPTH=4 while spi_busy is held 1 -> tx_full=1 after 4 writes, 5th dropped, and tx_ovf=1 when the macro is defined.
REQ-040 Fill RX (4 transfers, no reads), queue a 5th -> FSM holds in STORE; one rd_en -> the 5th is stored and RX order is preserved.
REQ-041 Assert reset during WAIT_DONE -> spi_start=0, rx_empty=1, no late push after release.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and default sizing for the SPI transaction queue.
package spi_pkg;
  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_DONE,
    ST_STORE
  } state_e;
endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head is visible combinationally.
module spi_sync_fifo
  import spi_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int DEPTH     = DEF_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  output logic [DATA_BITS-1:0] rdata_o,
  output logic                 full_o,
  output logic                 empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]          wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic                 do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // A pop frees the slot the same cycle, so push-when-full succeeds alongside it.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign wptr_d  = wptr_q + {{AW{1'b0}}, do_push};
  assign rptr_d  = rptr_q + {{AW{1'b0}}, do_pop};

  assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/spi_txn_queue.sv
// Queues bytes to an SPI master and buffers the returned bytes.
// Optional sticky overflow flags: define SPI_TXN_QUEUE_ERR_EN.
module spi_txn_queue
  import spi_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 tx_full,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rx_empty,
  output logic                 spi_start,
  output logic [DATA_BITS-1:0] spi_master_out,
  input  logic                 spi_busy,
  input  logic                 spi_done,
  input  logic [DATA_BITS-1:0] spi_master_in,
  output logic                 idle
`ifdef SPI_TXN_QUEUE_ERR_EN
  ,output logic                tx_ovf,
  output logic                 rx_ovf
`endif
);
  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] out_q, out_d, cap_q, cap_d;
  logic                 tx_pop, tx_empty, rx_push, rx_full, rx_can;
  logic [DATA_BITS-1:0] tx_head;

  spi_sync_fifo #(.DATA_BITS(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx (
    .clk(clk), .reset(reset), .push_i(wr_en), .pop_i(tx_pop), .wdata_i(wr_data),
    .rdata_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
  );

  spi_sync_fifo #(.DATA_BITS(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx (
    .clk(clk), .reset(reset), .push_i(rx_push), .pop_i(rd_en), .wdata_i(cap_q),
    .rdata_o(rd_data), .full_o(rx_full), .empty_o(rx_empty)
  );

  // A full RX still accepts the push when the host pops in the same cycle.
  assign rx_can         = !rx_full || rd_en;
  assign spi_master_out = out_q;
  assign idle           = (state_q == ST_IDLE) && tx_empty;

  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    cap_d     = cap_q;
    tx_pop    = 1'b0;
    rx_push   = 1'b0;
    spi_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!tx_empty && !spi_busy) begin
          tx_pop  = 1'b1;
          out_d   = tx_head;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        spi_start = 1'b1;
        if (spi_busy) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (spi_done) begin
          cap_d   = spi_master_in;
          state_d = ST_STORE;
        end
      end
      ST_STORE: begin
        rx_push = 1'b1;
        if (rx_can) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cap_q   <= cap_d;
    end
  end

`ifdef SPI_TXN_QUEUE_ERR_EN
  logic tx_ovf_q, rx_ovf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
    end else begin
      tx_ovf_q <= tx_ovf_q | (wr_en && tx_full && !tx_pop);
      rx_ovf_q <= rx_ovf_q | ((state_q == ST_STORE) && !rx_can);
    end
  end

  assign tx_ovf = tx_ovf_q;
  assign rx_ovf = rx_ovf_q;
`endif
endmodule

// File: tb/tb_spi_txn_queue.sv
// Directed bench for spi_txn_queue with a reactive SPI master model.
module tb_spi_txn_queue;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       tx_full, rx_empty, spi_start, idle;
  logic [7:0] rd_data, spi_master_out;
  logic       spi_busy, spi_done = 1'b0;
  logic [7:0] spi_master_in = '0;
`ifdef SPI_TXN_QUEUE_ERR_EN
  logic       tx_ovf, rx_ovf;
`endif

  logic       hold_busy = 1'b0, m_busy = 1'b0;
  int         m_cnt = 0, cyc = 0, done_cyc = 0, last_gap = 0, done_cnt = 0, stab_err = 0;
  logic [7:0] cur = '0;
  logic [7:0] ret_q[$];
  logic [7:0] sent_q[$];
  int         checks = 0, errors = 0;
  logic       to;

  assign spi_busy = hold_busy | m_busy;

  always #5 clk = ~clk;

  spi_txn_queue dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full),
    .rd_en(rd_en), .rd_data(rd_data), .rx_empty(rx_empty), .spi_start(spi_start),
    .spi_master_out(spi_master_out), .spi_busy(spi_busy), .spi_done(spi_done),
    .spi_master_in(spi_master_in), .idle(idle)
`ifdef SPI_TXN_QUEUE_ERR_EN
    ,.tx_ovf(tx_ovf), .rx_ovf(rx_ovf)
`endif
  );

  // SPI master model: busy for three cycles after a start, then a done pulse.
  always @(negedge clk) begin
    cyc++;
    spi_done = 1'b0;
    if (!reset) begin
      m_busy = 1'b0;
      m_cnt  = 0;
    end else if (m_busy) begin
      if (spi_master_out !== cur) stab_err++;
      if (m_cnt == 0) begin
        spi_done      = 1'b1;
        spi_master_in = (ret_q.size() > 0) ? ret_q.pop_front() : 8'h00;
        m_busy        = 1'b0;
        done_cnt++;
        done_cyc = cyc;
      end else m_cnt--;
    end else if (spi_start) begin
      m_busy   = 1'b1;
      m_cnt    = 2;
      cur      = spi_master_out;
      sent_q.push_back(cur);
      last_gap = cyc - done_cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [7:0] b);
    wr_data = b; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] exp);
    chk(tag, rd_data, exp);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic wait_idle(output logic timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (idle && !spi_busy && !spi_done) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    chk("rst_idle", idle, 1);
    chk("rst_start", spi_start, 0);
    chk("rst_rx_empty", rx_empty, 1);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_mout", spi_master_out, 0);
`ifdef SPI_TXN_QUEUE_ERR_EN
    chk("rst_tx_ovf", tx_ovf, 0);
    chk("rst_rx_ovf", rx_ovf, 0);
`endif
    reset = 1'b1;
    step();

    // Single transfer
    sent_q.delete();
    ret_q.push_back(8'h77);
    wr(8'hA5);
    chk("single_not_idle", idle, 0);
    wait_idle(to);
    chk("single_timeout", to, 0);
    chk("single_cnt", sent_q.size(), 1);
    chk("single_sent", sent_q[0], 8'hA5);
    chk("single_rx_empty", rx_empty, 0);
    rd("single_rd", 8'h77);
    chk("single_rx_drained", rx_empty, 1);

    // Back-to-back transfers
    sent_q.delete();
    ret_q.push_back(8'h76);
    ret_q.push_back(8'h46);
    wr(8'hA1);
    wr(8'hA3);
    wait_idle(to);
    chk("b2b_timeout", to, 0);
    chk("b2b_cnt", sent_q.size(), 2);
    chk("b2b_sent0", sent_q[0], 8'hA1);
    chk("b2b_sent1", sent_q[1], 8'hA3);
    chk("b2b_gap", (last_gap <= 4), 1);
    rd("b2b_rd0", 8'h76);
    rd("b2b_rd1", 8'h46);
    chk("b2b_rx_empty", rx_empty, 1);

    // TX overflow while the master is held busy
    sent_q.delete();
    hold_busy = 1'b1;
    wr(8'hC0); wr(8'hC1); wr(8'hC2);
    chk("ovf_not_full3", tx_full, 0);
    wr(8'hC3);
    chk("ovf_full4", tx_full, 1);
`ifdef SPI_TXN_QUEUE_ERR_EN
    chk("ovf_tx_ovf0", tx_ovf, 0);
`endif
    wr(8'hC4);
    chk("ovf_full5", tx_full, 1);
`ifdef SPI_TXN_QUEUE_ERR_EN
    chk("ovf_tx_ovf1", tx_ovf, 1);
`endif
    chk("ovf_no_start", sent_q.size(), 0);
    for (int i = 0; i < 4; i++) ret_q.push_back(8'h20 + 8'(i));
    hold_busy = 1'b0;
    wait_idle(to);
    chk("ovf_timeout", to, 0);
    chk("ovf_cnt", sent_q.size(), 4);
    for (int i = 0; i < 4; i++) chk("ovf_sent", sent_q[i], 8'hC0 + 8'(i));
    for (int i = 0; i < 4; i++) rd("ovf_rd", 8'h20 + 8'(i));
    chk("ovf_rx_empty", rx_empty, 1);

    // RX full stalls the FSM in STORE
    sent_q.delete();
    done_cnt = 0;
    for (int i = 0; i < 5; i++) ret_q.push_back(8'h10 + 8'(i));
    for (int i = 0; i < 5; i++) wr(8'hD0 + 8'(i));
    to = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (done_cnt >= 5) begin to = 1'b0; break; end
      step();
    end
    chk("stall_timeout", to, 0);
    repeat (6) step();
    chk("stall_cnt", sent_q.size(), 5);
    chk("stall_not_idle", idle, 0);
    chk("stall_no_start", spi_start, 0);
    chk("stall_rx_nonempty", rx_empty, 0);
`ifdef SPI_TXN_QUEUE_ERR_EN
    chk("stall_rx_ovf", rx_ovf, 1);
`endif
    rd("stall_rd0", 8'h10);
    wait_idle(to);
    chk("stall_release_timeout", to, 0);
    for (int i = 1; i < 5; i++) rd("stall_rd", 8'h10 + 8'(i));
    chk("stall_rx_empty", rx_empty, 1);
    for (int i = 0; i < 5; i++) chk("stall_sent", sent_q[i], 8'hD0 + 8'(i));

    // Reset during WAIT_DONE
    sent_q.delete();
    ret_q.push_back(8'h55);
    wr(8'hE0);
    to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (m_busy && !spi_start) begin to = 1'b0; break; end
      step();
    end
    chk("abort_reach_wait", to, 0);
    reset = 1'b0;
    #1;
    chk("abort_start", spi_start, 0);
    chk("abort_rx_empty", rx_empty, 1);
    chk("abort_idle", idle, 1);
    chk("abort_mout", spi_master_out, 0);
    ret_q.delete();
    repeat (3) step();
    reset = 1'b1;
    repeat (20) step();
    chk("abort_no_push", rx_empty, 1);
    chk("abort_no_relaunch", sent_q.size(), 1);
    chk("abort_idle_after", idle, 1);
`ifdef SPI_TXN_QUEUE_ERR_EN
    chk("abort_tx_ovf_clr", tx_ovf, 0);
    chk("abort_rx_ovf_clr", rx_ovf, 0);
`endif

    chk("mout_stable", stab_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
